isram_arbiter: RTL

Shares the single-port 64-bit instruction SRAM between the fetch stage and the load/store unit (LSU), which uses it for data accesses to instruction memory. Each cycle it grants one requester, drives the SRAM port, and routes read data back one cycle later. It generates lr_isram_cs / lr_isram_cs_ff for the fetch stage. A run-length counter stops LSU priority from starving fetch.

---
 rtl/isram_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/isram_arbiter.sv
// isram_arbiter: shares the single-port instruction SRAM between fetch and the LSU.
// Optional feature macro: ISRAM_FETCH_HOLD_EN adds a fetch-word hold register.
module isram_arbiter #(
    parameter int MAX_LS_RUN = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        fet_req,
    input  logic [28:0] fet_adr,
    output logic        fet_gnt,
    output logic        fet_rvalid,
    output logic [63:0] fet_rdata,
    output logic        fet_stall,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [28:0] ls_adr,
    input  logic [63:0] ls_wdata,
    input  logic [7:0]  ls_wmask,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [63:0] ls_rdata,
    output logic        lr_isram_cs,
    output logic        lr_isram_cs_ff,
    output logic        isram_cs,
    output logic        isram_we,
    output logic [28:0] isram_adr,
    output logic [63:0] isram_wdata,
    output logic [7:0]  isram_wmask,
    input  logic [63:0] isram_rdata
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FET  = 2'd1,
        S_LSR  = 2'd2,
        S_LSW  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] w_run_cnt_next;
    logic             r_lr_cs_ff;
    logic             w_force_fet;

    // LSU has priority unless it has starved a pending fetch for MAX_LS_RUN grants
    always_comb begin
        w_force_fet    = fet_req & ls_req & (r_run_cnt == CNT_W'(MAX_LS_RUN));
        ls_gnt         = ~cpurst & ls_req & ~w_force_fet;
        fet_gnt        = ~cpurst & fet_req & ~ls_gnt;
        isram_cs       = ls_gnt | fet_gnt;
        isram_we       = ls_gnt & ls_we;
        isram_adr      = ls_gnt ? ls_adr : fet_adr;
        isram_wdata    = ls_wdata;
        isram_wmask    = isram_we ? ls_wmask : 8'h00;
        w_next_state   = fet_gnt ? S_FET : ls_gnt ? (ls_we ? S_LSW : S_LSR) : S_IDLE;
        w_run_cnt_next = (fet_gnt | ~fet_req) ? '0 :
                         (ls_gnt && r_run_cnt != CNT_W'(MAX_LS_RUN)) ? r_run_cnt + CNT_W'(1) :
                         r_run_cnt;
    end

    // Remember last cycle's access so read data can be steered back a cycle later
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            r_state    <= S_IDLE;
            r_run_cnt  <= '0;
            r_lr_cs_ff <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_run_cnt  <= w_run_cnt_next;
            r_lr_cs_ff <= ls_gnt;
        end
    end

    assign fet_stall      = fet_req & ~fet_gnt;
    assign lr_isram_cs    = ls_gnt;
    assign lr_isram_cs_ff = r_lr_cs_ff;
    assign fet_rvalid     = (r_state == S_FET);
    assign ls_rvalid      = (r_state == S_LSR);
    assign ls_rdata       = isram_rdata;

`ifdef ISRAM_FETCH_HOLD_EN
    logic [63:0] r_fet_hold;

    // Keep the last fetch word so LSU reads cannot clobber what fetch sees
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst)
            r_fet_hold <= '0;
        else if (fet_rvalid)
            r_fet_hold <= isram_rdata;
    end

    assign fet_rdata = r_lr_cs_ff ? r_fet_hold : isram_rdata;
`else
    assign fet_rdata = isram_rdata;
`endif
endmodule
